dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store port (port 0) and an external loader/debug port (port 1). It sits between the datapath's memory address/write-data outputs and the data memory. It grants at most one access per cycle and returns read data with fixed one-cycle latency. It also supports a lock so that a read-modify-write sequence cannot be interleaved, and a lock watchdog that prevents the other port from starving.

## Interface
- `LOCK_TIMEOUT`, default 16: maximum consecutive cycles a port may hold the lock, counted from lock entry.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: access request; held high with fields stable until granted.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `be0`, `be1` in 4: byte enables for the write.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: write data.
- `lock0`, `lock1` in 1: request to keep ownership after this grant.
- `gnt0`, `gnt1` out 1: combinational; access accepted this cycle.
- `rvalid0`, `rvalid1` out 1: read data valid; registered.
- `rdata0`, `rdata1` out 32: read data; equals `mem_rdata` when the matching `rvalid` is high, otherwise 0.
- `cpu_stall` out 1: `req0 & ~gnt0`; used to hold the CPU's PC register.
- `lock_err` out 1: one-cycle pulse when the watchdog breaks a lock.
- `mem_en`, `mem_we` out 1: memory strobe and write enable.
- `mem_be` out 4: byte enables to memory.
- `mem_addr`, `mem_wdata` out 32: address and write data to memory.
- `mem_rdata` in 32: synchronous-read memory output, valid one cycle after `mem_en` with `mem_we=0`.

## Operation
- **States:**
  - `IDLE`: either port may win.
  - `LOCK0`: only port 0 may be granted.
  - `LOCK1`: only port 1 may be granted.
- **`IDLE` arbitration:**
  - A single requester wins.
  - When both ports request, the winner is chosen by the configured policy (see Configuration).
- **Lock entry:** when winner k is granted with `lock_k=1`, the next state is `LOCKk` and `lock_cnt` is loaded with 0.
- **In `LOCKk`:**
  - `gnt_k = req_k`; the other port's grant is 0 regardless of its request.
  - `lock_cnt` increments each cycle.
  - Exit to `IDLE` on the clock edge where `lock_k` is sampled 0. A grant issued in that same cycle still goes only to k.
  - If `lock_k` is sampled 1 in the same cycle that `lock_cnt == LOCK_TIMEOUT-1`, the next state is `IDLE`, `lock_err` pulses in the following cycle, and `lock_cnt` is cleared. That cycle's grant still goes to k.
- **`last_gnt` register:** updates to k on every grant to port k; holds its value when nothing is granted.
- **Memory outputs:** `mem_*` are driven from the granted port's fields. When there is no grant, `mem_en=0`, `mem_we=0`, and `mem_be`, `mem_addr` and `mem_wdata` are all 0.
- **Read return:** a read grant to port k sets `rvalid_k` for exactly the next cycle. Writes produce no `rvalid`.
- **Pipelining:** back-to-back grants are allowed. A read granted in cycle n returns in cycle n+1 while a new access can be granted in cycle n+1.

## Timing
- Grant decision: combinational, 0 cycles. Read latency: 1 cycle, grant to `rvalid`. Write: completes in the grant cycle.
- Throughput: 1 access per cycle.
- Reset values: state `IDLE`, `last_gnt=1`, `lock_cnt=0`, `rvalid0=rvalid1=0`, `lock_err=0`. `rdata0` and `rdata1` are 0. The combinational outputs follow their inputs.
- Reset mid-operation: a pending `rvalid` is dropped (not asserted after reset), and any held lock is released.
- Simultaneous requests with `lock` set on both ports: only the winner enters the lock; the loser waits.
- A request that goes unanswered stays pending. The requester must hold its fields until `gnt`; the arbiter does not latch them.

## Configuration
- **`DMEM_ARB_RR_EN` defined:** round-robin. On a conflict in `IDLE`, the port not equal to `last_gnt` wins. Because `last_gnt` resets to 1, port 0 wins the first conflict after reset.
- **`DMEM_ARB_RR_EN` undefined:** fixed priority. Port 0 always wins a conflict in `IDLE`. `last_gnt` is still maintained but does not affect arbitration.

## Test plan
- **Reset readback:** read after reset. Port 0 reads `addr 0x10` holding `0xDEADBEEF` → `gnt0=1` the same cycle, `rvalid0=1` and `rdata0=0xDEADBEEF` the next cycle, `rvalid1=0`.
- **Conflict:** `req0` and `req1` both held for 4 cycles.
  - With RR: grants go 0,1,0,1.
  - Without RR: grants go 0,0,0,0, and `cpu_stall=0` throughout.
- **Lock:** port 1 sets `lock1`, reads `0x20`, then writes `0x20` with `be=4'b0011`, then drops `lock1`. Port 0 requests continuously and gets `gnt0=0` until the cycle after `lock1` is sampled 0. `cpu_stall=1` meanwhile.
- **Watchdog:** with `LOCK_TIMEOUT=4`, port 0 holds `lock0=1` indefinitely → exactly 4 locked cycles occur, then `IDLE`. `lock_err` is high for 1 cycle, and port 1 is granted.
- **Mid-read reset:** `reset` is asserted the cycle after a read grant → `rvalid0=0` in the following cycle, and the state is `IDLE`.
- **Pipelined reads:** reads to `0x0`, `0x4`, `0x8` on consecutive cycles → `rvalid0` is high for 3 consecutive cycles, with data in order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with lock and lock watchdog
// Optional feature macro: DMEM_ARB_RR_EN (round-robin conflict resolution in IDLE;
// undefined = fixed priority, port 0 wins).
module dmem_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [3:0]  be0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        lock0,
  input  logic        req1,
  input  logic        we1,
  input  logic [3:0]  be1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        cpu_stall,
  output logic        lock_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // Counter only has to reach LOCK_TIMEOUT-1; it is cleared whenever the lock ends.
  localparam int              CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             lock_err_q, lock_err_d;

  // Grant decision: owner-only while locked, single requester or policy winner when idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      ST_LOCK0: gnt0 = req0;
      ST_LOCK1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
          if (last_gnt_q == 1'b0) begin
            gnt1 = 1'b1;
          end else begin
            gnt0 = 1'b1;
          end
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

  // Lock state machine, lock age counter and watchdog break detection.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = 1'b0;
    case (state_q)
      ST_LOCK0: begin
        if (!lock0) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          lock_err_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      ST_LOCK1: begin
        if (!lock1) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          lock_err_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        if (gnt0 && lock0) begin
          state_d = ST_LOCK0;
        end else if (gnt1 && lock1) begin
          state_d = ST_LOCK1;
        end
      end
    endcase
  end

  // Grant history and read-return flags for the next cycle.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt1) begin
      last_gnt_d = 1'b1;
    end else if (gnt0) begin
      last_gnt_d = 1'b0;
    end
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
  end

  // Memory request mux: fields of the granted port, all zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_be    = be0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_be    = be1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // State registers; reset drops pending read returns and releases any lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Read data is steered to the port whose read is returning; zero otherwise.
  always_comb begin
    rvalid0   = rvalid0_q;
    rvalid1   = rvalid1_q;
    rdata0    = rvalid0_q ? mem_rdata : 32'h0;
    rdata1    = rvalid1_q ? mem_rdata : 32'h0;
    lock_err  = lock_err_q;
    cpu_stall = req0 && !gnt0;
  end

endmodule
